// File: rtl/dec3to8_pkg.sv
// Shared types for the streaming 3-to-8 decoder.
// Optional build macro: DEC3TO8_REENC_EN (adds out_top re-encode port).
package dec3to8_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 1 << CODE_W;
  localparam int CNT_W    = 4;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    onehot_t onehot;
    onehot_t mask;
    logic    last;
    cnt_t    count;
  } entry_t;

endpackage

// File: rtl/dec3to8_core.sv
// Combinational code -> one-hot decode.
// Every code value is legal; exactly one output bit is set.
module dec3to8_core #(
  parameter int CODE_W = 3
) (
  input  logic [CODE_W-1:0]        code,
  output logic [(1<<CODE_W)-1:0]   onehot
);

  localparam int OH_W = 1 << CODE_W;

  always_comb begin
    onehot = '0;
    for (int k = 0; k < OH_W; k++) begin
      if (code == CODE_W'(k)) onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/dec3to8_stream.sv
// Streaming decoder with burst mask/count accumulator and 2-entry skid buffer.
// Build macro DEC3TO8_REENC_EN adds out_top (highest set bit of out_mask).
module dec3to8_stream
  import dec3to8_pkg::buf_state_t;
  import dec3to8_pkg::EMPTY;
  import dec3to8_pkg::ONE;
  import dec3to8_pkg::FULL;
#(
  parameter int CODE_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CODE_W-1:0]       in_code,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<CODE_W)-1:0]  out_onehot,
  output logic [(1<<CODE_W)-1:0]  out_mask,
  output logic                    out_last,
`ifdef DEC3TO8_REENC_EN
  output logic [CODE_W-1:0]       out_top,
`endif
  output logic [CNT_W-1:0]        out_count
);

  localparam int OH_W = 1 << CODE_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [OH_W-1:0]  onehot;
    logic [OH_W-1:0]  mask;
    logic             last;
    logic [CNT_W-1:0] count;
  } ent_t;

  buf_state_t       state_q;
  buf_state_t       state_d;
  ent_t             head_q;
  ent_t             tail_q;
  ent_t             new_ent;
  logic [OH_W-1:0]  dec_oh;
  logic [OH_W-1:0]  acc_mask_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic             in_ready_q;
  logic             push;
  logic             pop;
  logic             load_head;
  logic             load_tail;
  logic             shift;

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q != EMPTY) & out_ready;

  dec3to8_core #(
    .CODE_W (CODE_W)
  ) u_core (
    .code   (in_code),
    .onehot (dec_oh)
  );

  always_comb begin
    new_ent        = '0;
    new_ent.onehot = dec_oh;
    new_ent.mask   = acc_mask_q | dec_oh;
    new_ent.last   = in_last;
    new_ent.count  = (acc_cnt_q == CNT_MAX) ? CNT_MAX
                                            : acc_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Head is refilled directly when it is the only live slot,
  // otherwise the tail slot absorbs the push until the head drains.
  assign load_head = push & ((state_q == EMPTY) |
                             ((state_q == ONE) & pop));
  assign load_tail = push & (state_q == ONE) & ~pop;
  assign shift     = pop & (state_q == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case (1'b1)
        load_head: head_q <= new_ent;
        shift:     head_q <= tail_q;
        default:   head_q <= head_q;
      endcase
      if (load_tail) tail_q <= new_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_mask_q <= '0;
      acc_cnt_q  <= '0;
    end else if (push) begin
      if (in_last) begin
        acc_mask_q <= '0;
        acc_cnt_q  <= '0;
      end else begin
        acc_mask_q <= new_ent.mask;
        acc_cnt_q  <= new_ent.count;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = out_valid ? head_q.onehot : '0;
  assign out_mask   = out_valid ? head_q.mask   : '0;
  assign out_last   = out_valid & head_q.last;
  assign out_count  = out_valid ? head_q.count  : '0;

`ifdef DEC3TO8_REENC_EN
  always_comb begin
    out_top = '0;
    for (int k = 0; k < OH_W; k++) begin
      if (out_mask[k]) out_top = CODE_W'(k);
    end
  end
`endif

endmodule

// File: doc/dec3to8_stream.md
Name: dec3to8_stream

Overview:
- Streaming 3-to-8 decoder: the receive end of the 3-bit priority-encoded index path. Consumes codes and emits the matching one-hot word.
- Also accumulates a burst mask, the OR of all one-hots since the last `in_last`, plus a saturating beat count.
- Valid/ready on both sides; a 2-entry skid buffer gives full throughput with a registered `in_ready`.
- Sits between an encoder-side producer and request-mask consumers.

Parameters:
- CODE_W, 3, code width; one-hot/mask width is ONEHOT_W = 2**CODE_W (8 at default)
- CNT_W, 4, burst beat-count width; saturates at 2**CNT_W-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat; registered
- in_code  in  CODE_W  index to decode
- in_last  in  1  final beat of burst
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output beat
- out_onehot  out  ONEHOT_W  one-hot of this beat's code
- out_mask  out  ONEHOT_W  inclusive running OR of the burst through this beat
- out_last  out  1  copy of in_last for this beat
- out_count  out  CNT_W  beats in the burst through this beat, saturating

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0, including in_ready.
  - Buffer state EMPTY; accumulator mask and count cleared.
  - in_ready rises on the first rising clk edge after rst_n deasserts.
- Accept on in_valid && in_ready; emit on out_valid && out_ready. in_code/in_last are sampled only on accept.
- Decode: out_onehot bit k is 1 iff code == k; exactly one bit set. All codes 0..2**CODE_W-1 are legal; there is no invalid code.
- Per accepted beat, the stored entry is:
  - onehot = dec(code)
  - mask = acc_mask | onehot
  - count = min(acc_cnt+1, 2**CNT_W-1)
  - last = in_last
- Accumulator update on accept:
  - in_last=1: acc_mask <= 0, acc_cnt <= 0, so the next beat starts a new burst.
  - otherwise: acc_mask <= entry.mask, acc_cnt <= entry.count.
- A repeated code within a burst leaves the mask unchanged but still increments the count.
- Buffer FSM, states EMPTY / ONE / FULL:
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push+pop -> ONE.
  - FULL: pop -> ONE. Push cannot occur because in_ready=0.
- in_ready: next value is (next_state != FULL).
- out_valid = (state != EMPTY). Outputs come from the head entry.
- Latency: a beat accepted at edge N appears on out_* after edge N, i.e. one cycle, when the buffer is EMPTY or draining.
- Stall: while out_valid && !out_ready, all out_* are held stable. Ordering is strictly FIFO.
- Throughput: one beat per cycle sustained when out_ready is held high.
- Reset mid-burst or mid-stall discards buffered entries and the partial accumulator; no partial burst survives.

Optional Feature:
- Macro: DEC3TO8_REENC_EN
- Defined:
  - Adds output `out_top` [CODE_W-1:0], the index of the highest set bit of out_mask (priority re-encode of the head entry).
  - Combinational from the head entry; 0 when out_valid=0.
  - Used for round-trip checking against the encoder.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package dec3to8_pkg:
  - CODE_W/ONEHOT_W constants
  - code_t, onehot_t typedefs
  - buf_state_t enum {EMPTY, ONE, FULL}
  - entry struct {onehot, mask, last, count}
- One sub-module, dec3to8_core: pure combinational code -> one-hot decode.
- Skid buffer and accumulator are inline in dec3to8_stream.

Test Plan:
- Reset and basic decode:
  - Check all outputs 0 during reset and in_ready=1 one cycle after release.
  - Then send code 3'b101, last=1 -> next cycle out_onehot=8'b00100000, out_mask=8'b00100000, count=1, last=1.
- Burst accumulation:
  - Codes 7,5,1,0 with last on 0 -> masks 8'h80, 8'hA0, 8'hA2, 8'hA3; counts 1,2,3,4.
  - Next burst: code 2 -> mask 8'h04, count 1.
- Backpressure:
  - Hold out_ready=0 and push 2 beats -> in_ready=0 after the 2nd, outputs stable.
  - Release -> beats drain in order and in_ready returns to 1.
- Full throughput: out_ready=1, in_valid=1 for 16 cycles of codes 0..7 repeated -> one output per cycle, no bubbles, count saturates at 15.
- Reset mid-burst:
  - Send codes 6,4 (no last), assert rst_n low, release, send code 0 with last=1 -> mask 8'h01, count 1.
- DEC3TO8_REENC_EN:
  - After burst codes 1,6 -> out_top=3'd6 on the 2nd beat.
  - Build without the macro -> compiles with no `out_top` port.
